// File: rtl/vscale_htif_pcr_arbiter.sv
// Round-robin arbiter sharing one HTIF PCR channel among NREQ requesters, one transaction in flight.
// Latency: accept at T -> core req at T+1; core resp at R -> requester resp at R+1. Backpressure from either side stalls the FSM in place.
module vscale_htif_pcr_arbiter #(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int IDW        = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            cu_req_valid,
  output logic [NREQ-1:0]            cu_req_ready,
  input  logic [NREQ-1:0]            cu_req_rw,
  input  logic [NREQ*ADDR_WIDTH-1:0] cu_req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] cu_req_data,
  output logic [NREQ-1:0]            cu_resp_valid,
  input  logic [NREQ-1:0]            cu_resp_ready,
  output logic [DATA_WIDTH-1:0]      cu_resp_data,
  output logic                       htif_pcr_req_valid,
  input  logic                       htif_pcr_req_ready,
  output logic                       htif_pcr_req_rw,
  output logic [ADDR_WIDTH-1:0]      htif_pcr_req_addr,
  output logic [DATA_WIDTH-1:0]      htif_pcr_req_data,
  input  logic                       htif_pcr_resp_valid,
  output logic                       htif_pcr_resp_ready,
  input  logic [DATA_WIDTH-1:0]      htif_pcr_resp_data,
  output logic                       busy,
  output logic [IDW-1:0]             grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state;
  logic [IDW-1:0]        last_grant;
  logic [IDW-1:0]        winner;
  logic                  found;
  logic                  any_req;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] resp_q;
  logic                  req_valid_q;
  logic                  resp_ready_q;
  logic [NREQ-1:0]       resp_valid_q;
  logic                  busy_q;

  // Two passes give the round-robin wrap: first indices above last_grant, then the rest.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i > int'(last_grant)) && cu_req_valid[i]) begin
        winner = IDW'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i <= int'(last_grant)) && cu_req_valid[i]) begin
        winner = IDW'(i);
        found  = 1'b1;
      end
    end
  end

  assign any_req = |cu_req_valid;

  always_comb begin
    cu_req_ready = '0;
    if ((state == IDLE) && !reset && any_req) begin
      cu_req_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= IDW'(NREQ - 1);
      grant_id     <= '0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      resp_q       <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      resp_valid_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            rw_q        <= cu_req_rw[winner];
            addr_q      <= cu_req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            data_q      <= cu_req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            grant_id    <= winner;
            req_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (htif_pcr_req_ready) begin
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          // Writes also get a response from the core, so every transaction passes through here.
          if (htif_pcr_resp_valid) begin
            resp_q       <= htif_pcr_resp_data;
            resp_ready_q <= 1'b0;
            resp_valid_q <= NREQ'(1) << grant_id;
            state        <= RESP;
          end
        end
        RESP: begin
          if (cu_resp_ready[grant_id]) begin
            resp_valid_q <= '0;
            last_grant   <= grant_id;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b0;
          resp_valid_q <= '0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign htif_pcr_req_valid  = req_valid_q;
  assign htif_pcr_req_rw     = rw_q;
  assign htif_pcr_req_addr   = addr_q;
  assign htif_pcr_req_data   = data_q;
  assign htif_pcr_resp_ready = resp_ready_q;
  assign cu_resp_valid       = resp_valid_q;
  assign cu_resp_data        = resp_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
// Directed bench for the HTIF PCR arbiter: two requesters, hand-driven core side.
module tb_vscale_htif_pcr_arbiter;

  logic         clk;
  logic         reset;
  logic [1:0]   cu_req_valid;
  logic [1:0]   cu_req_ready;
  logic [1:0]   cu_req_rw;
  logic [23:0]  cu_req_addr;
  logic [127:0] cu_req_data;
  logic [1:0]   cu_resp_valid;
  logic [1:0]   cu_resp_ready;
  logic [63:0]  cu_resp_data;
  logic         htif_pcr_req_valid;
  logic         htif_pcr_req_ready;
  logic         htif_pcr_req_rw;
  logic [11:0]  htif_pcr_req_addr;
  logic [63:0]  htif_pcr_req_data;
  logic         htif_pcr_resp_valid;
  logic         htif_pcr_resp_ready;
  logic [63:0]  htif_pcr_resp_data;
  logic         busy;
  logic [0:0]   grant_id;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;

  vscale_htif_pcr_arbiter #(.NREQ(2), .ADDR_WIDTH(12), .DATA_WIDTH(64), .IDW(1)) dut (
    .clk(clk), .reset(reset),
    .cu_req_valid(cu_req_valid), .cu_req_ready(cu_req_ready), .cu_req_rw(cu_req_rw),
    .cu_req_addr(cu_req_addr), .cu_req_data(cu_req_data),
    .cu_resp_valid(cu_resp_valid), .cu_resp_ready(cu_resp_ready), .cu_resp_data(cu_resp_data),
    .htif_pcr_req_valid(htif_pcr_req_valid), .htif_pcr_req_ready(htif_pcr_req_ready),
    .htif_pcr_req_rw(htif_pcr_req_rw), .htif_pcr_req_addr(htif_pcr_req_addr),
    .htif_pcr_req_data(htif_pcr_req_data), .htif_pcr_resp_valid(htif_pcr_resp_valid),
    .htif_pcr_resp_ready(htif_pcr_resp_ready), .htif_pcr_resp_data(htif_pcr_resp_data),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (htif_pcr_req_valid && htif_pcr_req_ready) hs_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task step;
    @(posedge clk);
    #1;
  endtask

  task apply_reset;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task test_reset;
    cu_req_valid = 2'b00; cu_req_rw = 2'b00; cu_req_addr = '0; cu_req_data = '0;
    cu_resp_ready = 2'b00; htif_pcr_req_ready = 1'b0; htif_pcr_resp_valid = 1'b0;
    htif_pcr_resp_data = '0;
    apply_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id: got %b want 0", grant_id); end
    checks++; if (cu_req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", cu_req_ready); end
    checks++; if (cu_resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b want 00", cu_resp_valid); end
    checks++; if (htif_pcr_req_valid !== 1'b0) begin errors++; $display("FAIL reset_core_req_valid: got %b want 0", htif_pcr_req_valid); end
    checks++; if (htif_pcr_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_core_resp_ready: got %b want 0", htif_pcr_resp_ready); end
    checks++; if (htif_pcr_req_addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", htif_pcr_req_addr); end
    checks++; if (cu_resp_data !== 64'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", cu_resp_data); end
  endtask

  task test_single_read;
    cu_resp_ready = 2'b11;
    htif_pcr_req_ready = 1'b1;
    cu_req_valid = 2'b01; cu_req_rw = 2'b00; cu_req_addr = {12'h000, 12'h780};
    #1;
    checks++; if (cu_req_ready !== 2'b01) begin errors++; $display("FAIL read_accept: got %b want 01", cu_req_ready); end
    checks++; if (htif_pcr_req_valid !== 1'b0) begin errors++; $display("FAIL read_no_early_req: got %b want 0", htif_pcr_req_valid); end
    step();
    cu_req_valid = 2'b00;
    #1;
    checks++; if (htif_pcr_req_valid !== 1'b1) begin errors++; $display("FAIL read_req_valid: got %b want 1", htif_pcr_req_valid); end
    checks++; if (htif_pcr_req_addr !== 12'h780) begin errors++; $display("FAIL read_req_addr: got %h want 780", htif_pcr_req_addr); end
    checks++; if (htif_pcr_req_rw !== 1'b0) begin errors++; $display("FAIL read_req_rw: got %b want 0", htif_pcr_req_rw); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b want 1", busy); end
    step();
    checks++; if (htif_pcr_resp_ready !== 1'b1) begin errors++; $display("FAIL read_wait_ready: got %b want 1", htif_pcr_resp_ready); end
    step();
    htif_pcr_resp_valid = 1'b1; htif_pcr_resp_data = 64'h1;
    step();
    htif_pcr_resp_valid = 1'b0;
    #1;
    checks++; if (cu_resp_valid !== 2'b01) begin errors++; $display("FAIL read_resp_valid: got %b want 01", cu_resp_valid); end
    checks++; if (cu_resp_data !== 64'h1) begin errors++; $display("FAIL read_resp_data: got %h want 1", cu_resp_data); end
    checks++; if (htif_pcr_resp_ready !== 1'b0) begin errors++; $display("FAIL read_resp_ready_drop: got %b want 0", htif_pcr_resp_ready); end
    step();
    checks++; if (busy !== 1'b0 || cu_resp_valid !== 2'b00) begin errors++; $display("FAIL read_done: busy %b resp_valid %b want 0 00", busy, cu_resp_valid); end
  endtask

  task test_contention;
    logic [1:0] exp_ready [4];
    logic       exp_id [4];
    exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    cu_req_valid = 2'b11; cu_req_rw = 2'b00; cu_req_addr = {12'h222, 12'h111};
    cu_resp_ready = 2'b11; htif_pcr_req_ready = 1'b1;
    htif_pcr_resp_valid = 1'b1; htif_pcr_resp_data = 64'h10;
    apply_reset();
    #1;
    for (int t = 0; t < 4; t++) begin
      checks++; if (cu_req_ready !== exp_ready[t]) begin errors++; $display("FAIL contend_ready_%0d: got %b want %b", t, cu_req_ready, exp_ready[t]); end
      step();
      checks++; if (grant_id !== exp_id[t]) begin errors++; $display("FAIL contend_grant_%0d: got %b want %b", t, grant_id, exp_id[t]); end
      for (int c = 0; c < 3; c++) begin
        checks++; if (cu_req_ready !== 2'b00) begin errors++; $display("FAIL contend_busy_ready_%0d_%0d: got %b want 00", t, c, cu_req_ready); end
        step();
      end
      #1;
    end
    cu_req_valid = 2'b00;
    htif_pcr_resp_valid = 1'b0;
  endtask

  task test_core_backpressure;
    int hs0;
    cu_req_valid = 2'b01; cu_req_rw = 2'b01; cu_req_addr = {12'h000, 12'h123};
    cu_req_data = {64'h0, 64'h55AA};
    htif_pcr_req_ready = 1'b0; htif_pcr_resp_valid = 1'b0;
    step();
    cu_req_valid = 2'b00; cu_req_addr = {12'h000, 12'hFFF}; cu_req_data = '0; cu_req_rw = 2'b00;
    hs0 = hs_count;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (htif_pcr_req_valid !== 1'b1 || htif_pcr_req_addr !== 12'h123 || htif_pcr_req_data !== 64'h55AA || htif_pcr_req_rw !== 1'b1)
        begin errors++; $display("FAIL bp_hold_%0d: valid %b addr %h data %h rw %b want 1 123 55aa 1", i, htif_pcr_req_valid, htif_pcr_req_addr, htif_pcr_req_data, htif_pcr_req_rw); end
      step();
    end
    htif_pcr_req_ready = 1'b1;
    step();
    checks++; if (htif_pcr_req_valid !== 1'b0 || htif_pcr_resp_ready !== 1'b1) begin errors++; $display("FAIL bp_to_wait: req_valid %b resp_ready %b want 0 1", htif_pcr_req_valid, htif_pcr_resp_ready); end
    step();
    checks++; if (hs_count - hs0 !== 1) begin errors++; $display("FAIL bp_handshakes: got %0d want 1", hs_count - hs0); end
    htif_pcr_resp_valid = 1'b1; htif_pcr_resp_data = 64'hABCD;
    step();
    htif_pcr_resp_valid = 1'b0;
    #1;
    checks++; if (cu_resp_valid !== 2'b01 || cu_resp_data !== 64'hABCD) begin errors++; $display("FAIL bp_resp: valid %b data %h want 01 abcd", cu_resp_valid, cu_resp_data); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b want 0", busy); end
  endtask

  task test_write_resp_backpressure;
    cu_req_valid = 2'b11; cu_req_rw = 2'b10; cu_req_addr = {12'h781, 12'h000};
    cu_req_data = {64'hDEADBEEF, 64'h0};
    cu_resp_ready = 2'b00; htif_pcr_req_ready = 1'b1; htif_pcr_resp_valid = 1'b0;
    #1;
    checks++; if (cu_req_ready !== 2'b10) begin errors++; $display("FAIL wr_accept: got %b want 10", cu_req_ready); end
    step();
    cu_req_valid = 2'b01;
    #1;
    checks++; if (htif_pcr_req_rw !== 1'b1 || htif_pcr_req_addr !== 12'h781 || htif_pcr_req_data !== 64'hDEADBEEF)
      begin errors++; $display("FAIL wr_core_req: rw %b addr %h data %h want 1 781 deadbeef", htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data); end
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL wr_grant: got %b want 1", grant_id); end
    step();
    htif_pcr_resp_valid = 1'b1; htif_pcr_resp_data = 64'h0;
    #1;
    checks++; if (htif_pcr_resp_ready !== 1'b1) begin errors++; $display("FAIL wr_wait: got %b want 1", htif_pcr_resp_ready); end
    step();
    htif_pcr_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (cu_resp_valid !== 2'b10 || cu_resp_data !== 64'h0 || busy !== 1'b1 || cu_req_ready !== 2'b00)
        begin errors++; $display("FAIL wr_resp_hold_%0d: valid %b data %h busy %b ready %b want 10 0 1 00", i, cu_resp_valid, cu_resp_data, busy, cu_req_ready); end
      step();
    end
    cu_resp_ready = 2'b11;
    #1;
    checks++; if (cu_resp_valid !== 2'b10) begin errors++; $display("FAIL wr_resp_still: got %b want 10", cu_resp_valid); end
    step();
    checks++; if (cu_req_ready !== 2'b01 || busy !== 1'b0) begin errors++; $display("FAIL wr_next_grant: ready %b busy %b want 01 0", cu_req_ready, busy); end
    cu_req_valid = 2'b00;
  endtask

  task test_resp_guard;
    cu_req_valid = 2'b01; cu_req_rw = 2'b00; cu_req_addr = {12'h000, 12'h7C0};
    htif_pcr_req_ready = 1'b0;
    step();
    cu_req_valid = 2'b00;
    htif_pcr_resp_valid = 1'b1; htif_pcr_resp_data = 64'h77;
    #1;
    checks++; if (htif_pcr_resp_ready !== 1'b0) begin errors++; $display("FAIL guard_issue_ready: got %b want 0", htif_pcr_resp_ready); end
    step();
    checks++; if (busy !== 1'b1 || cu_resp_valid !== 2'b00 || htif_pcr_resp_ready !== 1'b0 || htif_pcr_req_valid !== 1'b1)
      begin errors++; $display("FAIL guard_no_capture: busy %b resp_valid %b resp_ready %b req_valid %b want 1 00 0 1", busy, cu_resp_valid, htif_pcr_resp_ready, htif_pcr_req_valid); end
    htif_pcr_resp_valid = 1'b0; htif_pcr_req_ready = 1'b1;
    step();
    checks++; if (cu_resp_valid !== 2'b00 || htif_pcr_resp_ready !== 1'b1) begin errors++; $display("FAIL guard_wait: resp_valid %b resp_ready %b want 00 1", cu_resp_valid, htif_pcr_resp_ready); end
    htif_pcr_resp_valid = 1'b1; htif_pcr_resp_data = 64'h99;
    step();
    htif_pcr_resp_valid = 1'b0;
    #1;
    checks++; if (cu_resp_valid !== 2'b01 || cu_resp_data !== 64'h99) begin errors++; $display("FAIL guard_resp: valid %b data %h want 01 99", cu_resp_valid, cu_resp_data); end
    step();
  endtask

  task test_reset_mid_wait;
    cu_req_valid = 2'b10; cu_req_rw = 2'b00; htif_pcr_req_ready = 1'b1; htif_pcr_resp_valid = 1'b0;
    step();
    cu_req_valid = 2'b00;
    step();
    checks++; if (htif_pcr_resp_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre_wait: resp_ready %b busy %b want 1 1", htif_pcr_resp_ready, busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    htif_pcr_resp_valid = 1'b1; htif_pcr_resp_data = 64'h5;
    #1;
    checks++; if (busy !== 1'b0 || cu_resp_valid !== 2'b00 || htif_pcr_resp_ready !== 1'b0 || htif_pcr_req_valid !== 1'b0)
      begin errors++; $display("FAIL rst_abandon: busy %b resp_valid %b resp_ready %b req_valid %b want 0 00 0 0", busy, cu_resp_valid, htif_pcr_resp_ready, htif_pcr_req_valid); end
    htif_pcr_resp_valid = 1'b0;
    cu_req_valid = 2'b11;
    #1;
    checks++; if (cu_req_ready !== 2'b01) begin errors++; $display("FAIL rst_priority: got %b want 01", cu_req_ready); end
    step();
    checks++; if (grant_id !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rst_grant: id %b busy %b want 0 1", grant_id, busy); end
    checks++; if (cu_resp_valid !== 2'b00) begin errors++; $display("FAIL rst_no_stale_resp: got %b want 00", cu_resp_valid); end
    cu_req_valid = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single_read();
    test_contention();
    test_core_backpressure();
    test_write_resp_backpressure();
    test_resp_guard();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vscale_htif_pcr_arbiter.md
Name: vscale_htif_pcr_arbiter

Overview:
- Shares the single HTIF PCR request/response channel of vscale_top between NREQ host-side requesters (e.g. tohost poller, debug/loader port).
- Round-robin arbitration; exactly one transaction outstanding on the core channel.
- Each response is routed back only to the requester that issued it.
- Sits between the host-side harness logic and the htif_pcr_* ports of vscale_top.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 12, CSR address width.
- DATA_WIDTH, 64, PCR data width.
- IDW, 1, grant index width (= clog2(NREQ), minimum 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cu_req_valid  in  NREQ  per-requester request valid.
- cu_req_ready  out  NREQ  per-requester request accept; one-hot or zero.
- cu_req_rw  in  NREQ  per-requester direction; 1 = write.
- cu_req_addr  in  NREQ*ADDR_WIDTH  flattened addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- cu_req_data  in  NREQ*DATA_WIDTH  flattened write data, same packing.
- cu_resp_valid  out  NREQ  per-requester response valid; one-hot or zero.
- cu_resp_ready  in  NREQ  per-requester response accept.
- cu_resp_data  out  DATA_WIDTH  shared response data bus.
- htif_pcr_req_valid  out  1  to core.
- htif_pcr_req_ready  in  1  from core.
- htif_pcr_req_rw  out  1  to core.
- htif_pcr_req_addr  out  ADDR_WIDTH  to core.
- htif_pcr_req_data  out  DATA_WIDTH  to core.
- htif_pcr_resp_valid  in  1  from core.
- htif_pcr_resp_ready  out  1  to core.
- htif_pcr_resp_data  in  DATA_WIDTH  from core.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  IDW  index of the current owner; holds its value while in IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset values:
  - state = IDLE; last_grant = NREQ-1, so requester 0 has first priority.
  - Latched rw/addr/data/resp registers cleared to 0; grant_id = 0.
  - All valid/ready outputs = 0.
- IDLE:
  - Winner = first i with cu_req_valid[i], searching upward from (last_grant+1) mod NREQ with wrap.
  - cu_req_ready[winner] = 1, driven combinationally in the same cycle; all other readies 0.
  - On that edge: latch the winner's rw/addr/data, set owner = winner, go to ISSUE.
  - If no request is valid, stay in IDLE.
- ISSUE:
  - htif_pcr_req_valid = 1; req_rw/addr/data driven from the latched registers and held stable.
  - On htif_pcr_req_valid & htif_pcr_req_ready, go to WAIT.
- WAIT:
  - htif_pcr_resp_ready = 1.
  - On htif_pcr_resp_valid: latch htif_pcr_resp_data, go to RESP.
  - Writes also wait for a response; the core returns one for every request.
- RESP:
  - cu_resp_valid[owner] = 1; cu_resp_data = latched data.
  - On cu_resp_ready[owner]: last_grant <= owner, go to IDLE.
- htif_pcr_resp_ready = 0 outside WAIT, so a core response can never be dropped or double-captured.
- cu_req_ready is 0 in every state except IDLE. No new request is accepted until the previous response has been consumed.
- Latency (zero stalls):
  - Accept at cycle T; htif_pcr_req_valid first high at T+1.
  - Core response at cycle R; cu_resp_valid high at R+1.
  - Earliest next accept is the cycle after the response handshake.
- Fairness: a requester that holds valid is granted within NREQ transactions.
  - Changes to cu_req_valid while busy do not affect the current transaction.
- cu_resp_data is undefined-but-stable outside RESP; it holds the last latched value.
- Reset asserted in any state:
  - Next edge returns to IDLE; all valids/readies are 0 that cycle and after.
  - The in-flight transaction is abandoned with no response to its requester.
  - last_grant = NREQ-1.

Test Plan:
- Single read: req0 valid, rw=0, addr=0x780, core req_ready=1, core returns 0x1 two cycles later -> cu_req_ready[0] high in cycle 0; htif_pcr_req_valid high cycle 1 with addr 0x780; cu_resp_valid[0] high with data 0x1 the cycle after the core response; cu_resp_valid[1] stays 0.
- Contention: req0 and req1 both held valid from reset for 4 transactions -> grant order 0,1,0,1; grant_id matches the order; never two readies high in one cycle.
- Core backpressure: htif_pcr_req_ready low for 5 cycles -> req_valid/addr/data held stable for those 5 cycles; exactly one request handshake occurs.
- Write, then requester backpressure: req1 write addr=0x781 data=0xDEADBEEF, core responds 0x0, cu_resp_ready[1] low for 3 cycles -> core sees rw=1 with that data; cu_resp_valid[1] held 3+ cycles; busy stays high; req0 is not granted until the response handshake completes.
- Response ordering guard: core asserts resp_valid during ISSUE -> htif_pcr_resp_ready = 0 and nothing is captured; the response is captured only in WAIT.
- Reset mid-WAIT: assert reset for 1 cycle while in WAIT -> next cycle busy = 0, all cu_resp_valid = 0, htif_pcr_resp_ready = 0; a subsequent simultaneous req0/req1 grants req0 first.
